// File: rtl/bram_pkg.sv
// Shared constants and elaboration helpers for the dual-port word RAM.
package bram_pkg;

  localparam int BYTE_W = 8;

  // Number of address bits needed to index n items; 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read return path: valid/data staging for a 1- or 2-cycle read latency.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          rd_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] do_o
);

  logic          v1_q;
  logic [DW-1:0] d1_q;

  // Data only moves on a read, so the output holds between reads.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_i;
      if (rd_i) d1_q <= data_i;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          v2_q;
    logic [DW-1:0] d2_q;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign vld_o = v2_q;
    assign do_o  = d2_q;
  end else begin : g_lat1
    assign vld_o = v1_q;
    assign do_o  = d1_q;
  end

endmodule

// File: rtl/bram_dp_ctrl.sv
// True dual-port byte-writable word RAM with read-first collisions and range checking.
// Optional power-up clear sweep is built when BRAM_CLEAR_EN is defined.
module bram_dp_ctrl
  import bram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 12,
  parameter int RD_LAT = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            a_en,
  input  logic [DW/8-1:0] a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_di,
  output logic [DW-1:0]   a_do,
  output logic            a_vld,
  input  logic            b_en,
  input  logic [DW/8-1:0] b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_di,
  output logic [DW-1:0]   b_do,
  output logic            b_vld,
  output logic            coll,
  output logic            err,
  output logic            busy
);

  localparam int NB     = DW / BYTE_W;
  localparam int OFF    = clog2(NB);
  localparam int IW     = AW - OFF;
  localparam int WIDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  if (!rd_lat_ok(RD_LAT) || (DW % BYTE_W) != 0) begin : g_bad_cfg
    $error("bram_dp_ctrl: RD_LAT must be 1 or 2 and DW a multiple of 8");
  end

  logic [DW-1:0]     mem_q [DEPTH];
  logic              clr_we;
  logic [WIDX_W-1:0] clr_idx;

  logic [IW-1:0] a_idx, b_idx;
  logic          a_oor, b_oor, a_acc, b_acc;
  logic          a_wr, b_wr, a_rd, b_rd;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          coll_q, err_q;

  assign a_idx = a_addr[AW-1:OFF];
  assign b_idx = b_addr[AW-1:OFF];
  assign a_oor = 32'(a_idx) >= DEPTH;
  assign b_oor = 32'(b_idx) >= DEPTH;
  assign a_acc = a_en & ~busy;
  assign b_acc = b_en & ~busy;
  assign a_wr  = a_acc & (a_we != '0) & ~a_oor;
  assign b_wr  = b_acc & (b_we != '0) & ~b_oor;
  assign a_rd  = a_acc & (a_we == '0);
  assign b_rd  = b_acc & (b_we == '0);

  // Array is sampled before this edge's writes land, giving read-first behaviour.
  assign a_rdata = a_oor ? '0 : mem_q[a_idx[WIDX_W-1:0]];
  assign b_rdata = b_oor ? '0 : mem_q[b_idx[WIDX_W-1:0]];

  // Port A is written last so its enabled bytes win a same-word collision.
  always_ff @(posedge CLK) begin
    if (clr_we) mem_q[clr_idx] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (b_wr && b_we[i])
        mem_q[b_idx[WIDX_W-1:0]][i*BYTE_W +: BYTE_W] <= b_di[i*BYTE_W +: BYTE_W];
      if (a_wr && a_we[i])
        mem_q[a_idx[WIDX_W-1:0]][i*BYTE_W +: BYTE_W] <= a_di[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      coll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      coll_q <= a_wr & b_wr & (a_idx == b_idx);
      err_q  <= (a_acc & a_oor) | (b_acc & b_oor);
    end
  end

  assign coll = coll_q;
  assign err  = err_q;

`ifdef BRAM_CLEAR_EN
  logic              busy_q;
  logic [WIDX_W-1:0] clr_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      busy_q <= 1'b1;
      clr_q  <= '0;
    end else if (busy_q) begin
      clr_q <= clr_q + 1'b1;
      if (clr_q == WIDX_W'(DEPTH - 1)) busy_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign clr_we  = busy_q;
  assign clr_idx = clr_q;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  bram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_a (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .rd_i   (a_rd),
    .data_i (a_rdata),
    .vld_o  (a_vld),
    .do_o   (a_do)
  );

  bram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_rd_b (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .rd_i   (b_rd),
    .data_i (b_rdata),
    .vld_o  (b_vld),
    .do_o   (b_do)
  );

endmodule
